// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Fetch front-end: strobes the instruction ROM, captures each word one
//   cycle later into an in-order FIFO, and presents the FIFO head to the
//   issue stage over a valid/ready handshake. Every in-flight ROM read owns
//   a reserved FIFO slot, so a returning ROM word always has room.
//
// Ports
//   clock            rising-edge clock
//   resetn           synchronous active-low reset
//   rom_read         ROM fetch strobe (ROM advances its address on each)
//   rom_instruction  ROM data, valid the cycle after rom_read
//   issue_valid      FIFO head holds an instruction
//   issue_instr      FIFO head word, 0 when empty
//   issue_ready      issue stage accepts the head this cycle
//   count            FIFO occupancy, 0..DEPTH
//   fetch_done       all PROG_LEN words accepted; sticky until reset
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter int unsigned PROG_LEN = 6,
  parameter int unsigned IW       = 16
) (
  input  logic            clock,
  input  logic            resetn,
  output logic            rom_read,
  input  logic [IW-1:0]   rom_instruction,
  output logic            issue_valid,
  output logic [IW-1:0]   issue_instr,
  input  logic            issue_ready,
  output logic [PTR_W:0]  count,
  output logic            fetch_done
);

  typedef enum logic {
    ST_FETCH,
    ST_DONE
  } state_e;

  localparam logic [8:0]       PROG_LEN_C = 9'(PROG_LEN);
  localparam logic [PTR_W+1:0] DEPTH_C    = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);

  logic [IW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             pend_q, pend_d;
  logic [8:0]       fetched_q, fetched_d;
  logic [8:0]       issued_q, issued_d;
  state_e           state_q, state_d;
  logic             push, pop;

  // Reservation counts the in-flight read (pend) as occupied and ignores a
  // same-cycle pop, so a returning word can never find the FIFO full.
  always_comb begin
    rom_read    = resetn && (fetched_q < PROG_LEN_C) &&
                  (({1'b0, count_q} + (PTR_W+2)'(pend_q)) < DEPTH_C);
    issue_valid = (count_q != '0);
    issue_instr = issue_valid ? mem_q[rd_ptr_q] : '0;
    push        = pend_q;
    pop         = issue_valid && issue_ready;
    count       = count_q;
    fetch_done  = (state_q == ST_DONE);
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    fetched_d = fetched_q;
    issued_d  = issued_q;
    state_d   = state_q;
    pend_d    = rom_read;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      issued_d = issued_q + 9'd1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (rom_read) fetched_d = fetched_q + 9'd1;

    case (state_q)
      ST_FETCH: if (issued_d == PROG_LEN_C) state_d = ST_DONE;
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pend_q    <= 1'b0;
      fetched_q <= '0;
      issued_q  <= '0;
      state_q   <= ST_FETCH;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      fetched_q <= fetched_d;
      issued_q  <= issued_d;
      state_q   <= state_d;
    end
  end

  // Storage has no reset; a word still in flight at reset is dropped.
  always_ff @(posedge clock) begin
    if (resetn && push) mem_q[wr_ptr_q] <= rom_instruction;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front-end for the Tomasulo core. It drives the read strobe of the 16-bit instruction ROM and captures each word one cycle later. Captured words are buffered in an in-order FIFO and presented to the issue stage over a valid/ready handshake. The ROM has no flow control, so the block reserves a FIFO slot for every in-flight read. A ROM word is never dropped.

## Interface
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- PTR_W, 2: log2(DEPTH).
- PROG_LEN, 6: number of ROM words to fetch; range 1..256.
- IW, 16: instruction width.

- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- rom_read  out  1  fetch strobe to the ROM; the ROM samples it on the rising edge and advances its address.
- rom_instruction  in  IW  ROM data; valid in the cycle after a cycle with rom_read=1.
- issue_valid  out  1  the FIFO head holds an instruction.
- issue_instr  out  IW  FIFO head word; 0 when issue_valid=0.
- issue_ready  in  1  the issue stage accepts the head this cycle.
- count  out  PTR_W+1  current FIFO occupancy, 0..DEPTH.
- fetch_done  out  1  all PROG_LEN words have been accepted by the issue stage; sticky until reset.

## Operation
- Registered state:
  - FIFO storage, rd_ptr/wr_ptr (PTR_W bits, wrap modulo DEPTH), count.
  - pend: 1-bit register, pend = rom_read of the previous cycle.
  - fetched and issued: 9-bit counters.
- rom_read, combinational from registers: resetn & (fetched < PROG_LEN) & (count + pend < DEPTH).
  - The reservation ignores a same-cycle pop. This is conservative and intentional.
- Push: on an edge where pend=1, write rom_instruction at wr_ptr, then wr_ptr+1 and count+1.
- Pop: on an edge where issue_valid & issue_ready, rd_ptr+1, count-1, issued+1.
- Push and pop on the same edge: count unchanged, both pointers advance.
- fetched increments on every edge with rom_read=1.
- Full: a push into a full FIFO cannot occur, because the reservation rule prevents it. The bench asserts this never happens.
- Empty: no bypass. A word pushed into an empty FIFO is first visible the following cycle.
- issue_valid = (count != 0).
- issue_instr = storage[rd_ptr] when count != 0, else 0.
- fetch_done sets when issued reaches PROG_LEN.
  - After that point rom_read=0, issue_valid=0 and the state is held.
- issue_ready while issue_valid=0 has no effect.
- Reset (resetn=0 at an edge) clears count, pointers, pend, fetched, issued and fetch_done.
  - Storage is not cleared.
  - rom_read is 0 throughout any cycle with resetn=0.
- Reset mid-operation: a pending ROM word is discarded. The ROM address is not rewound, so a restart resumes from the ROM's current address.

## Timing
- Reset values:
  - rom_read=0, issue_valid=0, issue_instr=0, count=0, fetch_done=0.
- Fetch latency:
  - rom_read=1 in cycle t.
  - The word is captured at the end of cycle t+1.
  - issue_valid=1 with that word in cycle t+2.
- Throughput: one word per cycle sustained with issue_ready held at 1. rom_read stays high continuously while words remain.
- With issue_ready=0 from reset, exactly DEPTH reads are issued, and then rom_read stays 0.
- After a pop from a full FIFO, rom_read reasserts in the next cycle (count=DEPTH-1, pend=0).
- fetch_done rises in the cycle after the edge that accepts word PROG_LEN.

## Test plan
- **Reset:** hold resetn=0 for 3 cycles with issue_ready=1.
  - rom_read, issue_valid, issue_instr, count and fetch_done are all 0 in every cycle.
- **Free run:** ROM model loaded with words W0..W5, PROG_LEN=6, issue_ready=1.
  - rom_read is high in cycles 0..5.
  - issue_valid is high in cycles 2..7, with issue_instr=W0..W5 in order.
  - fetch_done=1 from cycle 8; rom_read stays 0 thereafter.
- **Backpressure:** issue_ready=0.
  - rom_read is high for exactly 4 cycles, count settles at 4, and issue_instr=W0.
  - Raise issue_ready: W0..W5 are delivered in order with no duplicates or gaps.
- **Simultaneous push/pop:** count=2, pend=1, issue_ready=1.
  - count stays 2, both pointers advance, and the order of the delivered words is preserved.
- **Reset mid-fetch:** assert resetn=0 for one edge while pend=1.
  - Next cycle: count=0, issue_valid=0.
  - The discarded word never appears on issue_instr.
- **Toggling ready:** issue_ready alternates 1/0 every cycle.
  - All PROG_LEN words are delivered exactly once, in order.
  - count never exceeds DEPTH.
